// File: rtl/score_keeper.sv
// Pong match controller: per-player scores, serve delays, end-of-game and 7-segment digit masks.
// Optional BLINK_WINNER_EN blinks the winner's digit in GAME_OVER every BLINK_FRAMES frame ticks.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
`ifdef BLINK_WINNER_EN
  ,
  parameter int BLINK_FRAMES = 30
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_point_left,
  input  logic       i_point_right,
  input  logic       i_restart,
  output logic [6:0] o_digit_left,
  output logic [6:0] o_digit_right,
  output logic       o_serve,
  output logic       o_in_play,
  output logic       o_game_over,
  output logic       o_winner
);

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    PLAY       = 2'd1,
    POINT_HOLD = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [6:0] SEG_ZERO   = 7'h77;

  state_t     state_reg;
  logic [7:0] frame_cnt_reg;
  logic [3:0] score_left_reg;
  logic [3:0] score_right_reg;
  logic [6:0] seg_left;
  logic [6:0] seg_right;
  logic [6:0] shown_left;
  logic [6:0] shown_right;

  function automatic logic [6:0] seg7(input logic [3:0] value);
    logic [6:0] mask;
    case (value)
      4'd0:    mask = 7'h77;
      4'd1:    mask = 7'h24;
      4'd2:    mask = 7'h5D;
      4'd3:    mask = 7'h6D;
      4'd4:    mask = 7'h2E;
      4'd5:    mask = 7'h6B;
      4'd6:    mask = 7'h7B;
      4'd7:    mask = 7'h25;
      4'd8:    mask = 7'h7F;
      4'd9:    mask = 7'h6F;
      default: mask = 7'h00;
    endcase
    return mask;
  endfunction

  // Match FSM; restart outranks every other input in every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= SERVE_WAIT;
      frame_cnt_reg   <= 8'd0;
      score_left_reg  <= 4'd0;
      score_right_reg <= 4'd0;
      o_serve         <= 1'b0;
      o_in_play       <= 1'b0;
      o_game_over     <= 1'b0;
      o_winner        <= 1'b0;
    end else begin
      o_serve <= 1'b0;
      if (i_restart) begin
        state_reg       <= SERVE_WAIT;
        frame_cnt_reg   <= 8'd0;
        score_left_reg  <= 4'd0;
        score_right_reg <= 4'd0;
        o_in_play       <= 1'b0;
        o_game_over     <= 1'b0;
        o_winner        <= 1'b0;
      end else begin
        case (state_reg)
          SERVE_WAIT, POINT_HOLD: begin
            if (i_frame_tick) begin
              if (frame_cnt_reg == SERVE_LAST) begin
                frame_cnt_reg <= 8'd0;
                o_serve       <= 1'b1;
                o_in_play     <= 1'b1;
                state_reg     <= PLAY;
              end else begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
              end
            end
          end
          PLAY: begin
            // Left wins a same-cycle tie; the right pulse is simply dropped.
            if (i_point_left) begin
              score_left_reg <= score_left_reg + 4'd1;
              o_in_play      <= 1'b0;
              frame_cnt_reg  <= 8'd0;
              if (score_left_reg + 4'd1 == WIN_VAL) begin
                state_reg   <= GAME_OVER;
                o_game_over <= 1'b1;
                o_winner    <= 1'b0;
              end else begin
                state_reg <= POINT_HOLD;
              end
            end else if (i_point_right) begin
              score_right_reg <= score_right_reg + 4'd1;
              o_in_play       <= 1'b0;
              frame_cnt_reg   <= 8'd0;
              if (score_right_reg + 4'd1 == WIN_VAL) begin
                state_reg   <= GAME_OVER;
                o_game_over <= 1'b1;
                o_winner    <= 1'b1;
              end else begin
                state_reg <= POINT_HOLD;
              end
            end
          end
          GAME_OVER: begin
            state_reg <= GAME_OVER;
          end
        endcase
      end
    end
  end

  always_comb begin
    seg_left  = seg7(score_left_reg);
    seg_right = seg7(score_right_reg);
  end

`ifdef BLINK_WINNER_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] blink_cnt_reg;
  logic       blink_on_reg;
  logic       blink_hide;

  // Phase restarts visible on every GAME_OVER entry because it idles cleared elsewhere.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_reg <= 8'd0;
      blink_on_reg  <= 1'b1;
    end else if (i_restart || state_reg != GAME_OVER) begin
      blink_cnt_reg <= 8'd0;
      blink_on_reg  <= 1'b1;
    end else if (i_frame_tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= 8'd0;
        blink_on_reg  <= ~blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    blink_hide  = (state_reg == GAME_OVER) && !blink_on_reg;
    shown_left  = (blink_hide && !o_winner) ? 7'h00 : seg_left;
    shown_right = (blink_hide &&  o_winner) ? 7'h00 : seg_right;
  end
`else
  always_comb begin
    shown_left  = seg_left;
    shown_right = seg_right;
  end
`endif

  // Digits trail the score registers by one cycle; restart blanks them to "0" straight away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_digit_left  <= SEG_ZERO;
      o_digit_right <= SEG_ZERO;
    end else if (i_restart) begin
      o_digit_left  <= SEG_ZERO;
      o_digit_right <= SEG_ZERO;
    end else begin
      o_digit_left  <= shown_left;
      o_digit_right <= shown_right;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: expected outputs are queued as stimulus is driven and
// compared against the DUT after the relevant clock edge.
module tb_score_keeper;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b1;
  logic       frame_tick  = 1'b0;
  logic       point_left  = 1'b0;
  logic       point_right = 1'b0;
  logic       restart     = 1'b0;
  logic [6:0] digit_left;
  logic [6:0] digit_right;
  logic       serve;
  logic       in_play;
  logic       game_over;
  logic       winner;

  int tests = 0;
  int fails = 0;
  int sl    = 0;
  int sr    = 0;

  logic [6:0] seg_tab [10] = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E, 7'h6B, 7'h7B, 7'h25, 7'h7F, 7'h6F};

  typedef struct packed {
    logic [6:0] dl;
    logic [6:0] dr;
    logic       sv;
    logic       ip;
    logic       go;
    logic       wn;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  score_keeper #(
    .WIN_SCORE   (9),
    .SERVE_FRAMES(60)
`ifdef BLINK_WINNER_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (frame_tick),
    .i_point_left (point_left),
    .i_point_right(point_right),
    .i_restart    (restart),
    .o_digit_left (digit_left),
    .o_digit_right(digit_right),
    .o_serve      (serve),
    .o_in_play    (in_play),
    .o_game_over  (game_over),
    .o_winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [6:0] dl, input logic [6:0] dr,
                          input logic sv, input logic ip, input logic go, input logic wn);
    exp_t e;
    e.dl = dl; e.dr = dr; e.sv = sv; e.ip = ip; e.go = go; e.wn = wn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    exp_t  obs;
    string tag;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = {digit_left, digit_right, serve, in_play, game_over, winner};
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed dl=%h dr=%h sv=%b ip=%b go=%b wn=%b expected dl=%h dr=%h sv=%b ip=%b go=%b wn=%b",
               tag, obs.dl, obs.dr, obs.sv, obs.ip, obs.go, obs.wn, e.dl, e.dr, e.sv, e.ip, e.go, e.wn);
      end
      $display("[TB] %s checked dl=%h dr=%h sv=%b ip=%b go=%b wn=%b", tag,
               obs.dl, obs.dr, obs.sv, obs.ip, obs.go, obs.wn);
    end
  endtask

  task automatic give_tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  // 59 quiet ticks, then the 60th must produce exactly one serve pulse.
  task automatic do_serve(input string tag);
    for (int i = 0; i < 59; i++) give_tick();
    push_exp({tag, "_pre"}, seg_tab[sl], seg_tab[sr], 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    frame_tick = 1'b1;
    push_exp({tag, "_serve"}, seg_tab[sl], seg_tab[sr], 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    frame_tick = 1'b0;
    check_out();
    push_exp({tag, "_play"}, seg_tab[sl], seg_tab[sr], 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check_out();
  endtask

  task automatic score(input bit right, input bit with_tick, input string tag);
    logic [6:0] old_l;
    logic [6:0] old_r;
    logic       go;
    logic       wn;
    old_l = seg_tab[sl];
    old_r = seg_tab[sr];
    if (right) sr++; else sl++;
    go = (sl == 9) || (sr == 9);
    wn = right && go;
    point_left  = !right;
    point_right = right;
    frame_tick  = with_tick;
    push_exp({tag, "_reg"}, old_l, old_r, 1'b0, 1'b0, go, wn);
    cycle();
    point_left  = 1'b0;
    point_right = 1'b0;
    frame_tick  = 1'b0;
    check_out();
    push_exp({tag, "_digit"}, seg_tab[sl], seg_tab[sr], 1'b0, 1'b0, go, wn);
    cycle();
    check_out();
  endtask

  initial begin
    logic [6:0] blink_exp;
    bit         blink_en;
`ifdef BLINK_WINNER_EN
    blink_en = 1'b1;
`else
    blink_en = 1'b0;
`endif

    #2 rst_n = 1'b0;
    cycle();
    cycle();
    push_exp("reset", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b1;
    push_exp("idle", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_out();

    do_serve("serve1");

    // Point arrives together with a frame tick; that tick must not count toward the hold.
    score(1'b1, 1'b1, "right1");
    point_left  = 1'b1;
    point_right = 1'b1;
    cycle();
    point_left  = 1'b0;
    point_right = 1'b0;
    push_exp("hold_ignore", 7'h77, 7'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_out();
    do_serve("serve2");

    point_left  = 1'b1;
    point_right = 1'b1;
    cycle();
    point_left  = 1'b0;
    point_right = 1'b0;
    sl = 1;
    push_exp("both_points", 7'h24, 7'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_out();
    do_serve("serve3");

    while (sl < 8) begin
      score(1'b0, 1'b0, $sformatf("left%0d", sl + 1));
      do_serve($sformatf("serve_l%0d", sl));
    end
    score(1'b0, 1'b0, "left_win");

    point_left = 1'b1;
    cycle();
    point_left  = 1'b0;
    point_right = 1'b1;
    cycle();
    point_right = 1'b0;
    push_exp("over_ignore", 7'h6F, 7'h24, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check_out();

    for (int k = 1; k <= 4; k++) begin
      blink_exp = (blink_en && ((k / 2) % 2 == 1)) ? 7'h00 : 7'h6F;
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      push_exp($sformatf("over_tick%0d", k), blink_exp, 7'h24, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      check_out();
    end

    restart = 1'b1;
    cycle();
    restart = 1'b0;
    sl = 0;
    sr = 0;
    push_exp("restart", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();

    // Partial count, then restart held across ticks must leave the counter at zero.
    for (int i = 0; i < 30; i++) give_tick();
    restart = 1'b1;
    for (int i = 0; i < 3; i++) give_tick();
    restart = 1'b0;
    push_exp("restart_hold", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    do_serve("serve_after_hold");

    for (int k = 0; k < 9; k++) begin
      score(1'b1, 1'b0, $sformatf("right%0d", sr + 1));
      if (sr < 9) do_serve($sformatf("serve_r%0d", sr));
    end

    restart = 1'b1;
    cycle();
    restart = 1'b0;
    sl = 0;
    sr = 0;
    push_exp("restart2", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    do_serve("serve_r_restart");
    score(1'b1, 1'b0, "hold_point");
    for (int i = 0; i < 10; i++) give_tick();

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    sl = 0;
    sr = 0;
    push_exp("async_reset", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    cycle();
    rst_n = 1'b1;
    do_serve("serve_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
